ej5: RTL and testbench

//  - Single-digit BCD multiplier. Takes two BCD digits x and y (0..9) and

---
 rtl/ej5.sv | 57 +++++
 tb/tb_ej5.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ej5.sv
// ej5: single-digit BCD multiplier with one cycle of latency and a non-BCD operand flag.
// Optional macro EJ5_BIN_OUT_EN adds the registered binary product port bin_out.
module ej5 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] out,
  output logic       error,
  output logic       out_valid
`ifdef EJ5_BIN_OUT_EN
  ,output logic [6:0] bin_out
`endif
);
  logic        bad;
  logic [6:0]  p;
  logic [14:0] dd;
  logic [7:0]  out_d, out_q;
  logic        error_d, error_q;
  logic        out_valid_d, out_valid_q;
  always_comb begin
    bad = (x > 4'd9) || (y > 4'd9);
    p = {3'b0, x} * {3'b0, y};
    dd = {8'd0, p};
    // double-dabble: seven shifts move p into two BCD nibbles at dd[14:7]
    for (int i = 0; i < 7; i++) begin
      dd[10:7] = (dd[10:7] >= 4'd5) ? dd[10:7] + 4'd3 : dd[10:7];
      dd[14:11] = (dd[14:11] >= 4'd5) ? dd[14:11] + 4'd3 : dd[14:11];
      dd = dd << 1;
    end
    out_d = in_valid ? (bad ? 8'h00 : dd[14:7]) : out_q;
    error_d = in_valid ? bad : error_q;
    out_valid_d = in_valid;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_q <= 8'h00;
      error_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      error_q <= error_d;
      out_valid_q <= out_valid_d;
    end
  assign out = out_q;
  assign error = error_q;
  assign out_valid = out_valid_q;
`ifdef EJ5_BIN_OUT_EN
  logic [6:0] bin_d, bin_q;
  always_comb bin_d = in_valid ? (bad ? 7'd0 : p) : bin_q;
  always_ff @(posedge clk)
    if (!rst_n) bin_q <= 7'd0;
    else bin_q <= bin_d;
  assign bin_out = bin_q;
`endif
endmodule

// File: tb/tb_ej5.sv
// tb_ej5: directed vector table, hand-written corner sequences and an exhaustive sweep for ej5.
module tb_ej5;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic [7:0] out;
  logic       error;
  logic       out_valid;
`ifdef EJ5_BIN_OUT_EN
  logic [6:0] bin_out;
`endif
  int checks = 0;
  int errors = 0;

  ej5 dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .x(x),
    .y(y),
    .out(out),
    .error(error),
    .out_valid(out_valid)
`ifdef EJ5_BIN_OUT_EN
    ,.bin_out(bin_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] out;
    logic       err;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst_n = r;
    in_valid = v;
    x = a;
    y = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input string name, input logic [7:0] eo, input logic ee);
    chk({name, "_out"}, out, eo);
    chk({name, "_err"}, {7'd0, error}, {7'd0, ee});
    chk({name, "_vld"}, {7'd0, out_valid}, 8'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd3, 4'd2, 8'h06, 1'b0};
    vecs[1] = '{4'd1, 4'd0, 8'h00, 1'b0};
    vecs[2] = '{4'd5, 4'd4, 8'h20, 1'b0};
    vecs[3] = '{4'd9, 4'd9, 8'h81, 1'b0};
    vecs[4] = '{4'd8, 4'd7, 8'h56, 1'b0};
    vecs[5] = '{4'd4, 4'd2, 8'h08, 1'b0};
    vecs[6] = '{4'd2, 4'd4, 8'h08, 1'b0};
    vecs[7] = '{4'd1, 4'd9, 8'h09, 1'b0};
    vecs[8] = '{4'd2, 4'd5, 8'h10, 1'b0};
    vecs[9] = '{4'd15, 4'd15, 8'h00, 1'b1};

    drive(1'b0, 1'b1, 4'd9, 4'd9);
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    chk("rst_out", out, 8'h00);
    chk("rst_err", {7'd0, error}, 8'd0);
    chk("rst_vld", {7'd0, out_valid}, 8'd0);

    foreach (vecs[i]) begin
      drive(1'b1, 1'b1, vecs[i].x, vecs[i].y);
      expect_op($sformatf("vec%0d", i), vecs[i].out, vecs[i].err);
    end

    drive(1'b1, 1'b1, 4'd10, 4'd0);
    expect_op("err10", 8'h00, 1'b1);
    drive(1'b1, 1'b1, 4'd2, 4'd3);
    expect_op("err_clear", 8'h06, 1'b0);

    drive(1'b1, 1'b0, 4'd15, 4'd15);
    chk("hold_out", out, 8'h06);
    chk("hold_err", {7'd0, error}, 8'd0);
    chk("hold_vld", {7'd0, out_valid}, 8'd0);

    drive(1'b1, 1'b1, 4'd9, 4'd9);
    expect_op("b2b_0", 8'h81, 1'b0);
    drive(1'b1, 1'b1, 4'd7, 4'd6);
    expect_op("b2b_1", 8'h42, 1'b0);
    drive(1'b1, 1'b1, 4'd0, 4'd9);
    expect_op("b2b_2", 8'h00, 1'b0);

    drive(1'b1, 1'b1, 4'd8, 4'd7);
    expect_op("pre_rst", 8'h56, 1'b0);
    drive(1'b0, 1'b1, 4'd9, 4'd9);
    chk("rst_prio_out", out, 8'h00);
    chk("rst_prio_vld", {7'd0, out_valid}, 8'd0);
    chk("rst_prio_err", {7'd0, error}, 8'd0);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        automatic int prod = a * b;
        automatic logic bad = (a > 9) || (b > 9);
        automatic logic [7:0] eo = bad ? 8'h00 : {4'(prod / 10), 4'(prod % 10)};
        drive(1'b1, 1'b1, 4'(a), 4'(b));
        expect_op($sformatf("sweep_%0d_%0d", a, b), eo, bad);
`ifdef EJ5_BIN_OUT_EN
        chk($sformatf("bin_%0d_%0d", a, b), {1'b0, bin_out}, bad ? 8'd0 : 8'(prod));
`endif
      end

`ifdef EJ5_BIN_OUT_EN
    drive(1'b1, 1'b1, 4'd9, 4'd9);
    chk("bin_81", {1'b0, bin_out}, 8'd81);
`endif

    drive(1'b1, 1'b0, 4'd0, 4'd0);
    chk("final_vld", {7'd0, out_valid}, 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
